vga_sync_detector: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/sync_edge_detect.sv | 28 ++
 rtl/vga_sync_detector.sv | 164 ++++++++++++++++
 tb/tb_vga_sync_detector.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and sync-detector state encoding.
// Used by both the timing generator and the receive-side detector.
package vga_timing_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT
                               + VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT
                               + VGA_V_SYNC + VGA_V_BACK;

   // Sync start to first visible pixel/line
   localparam int VGA_H_ACT_OFS = VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_ACT_OFS = VGA_V_SYNC + VGA_V_BACK;

   localparam int VGA_H_TOL       = 2;
   localparam int VGA_LOCK_FRAMES = 2;

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } sync_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous active-low sync,
// plus an edge register producing a one-cycle falling-edge pulse.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= sync_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/vga_sync_detector.sv
// Measures incoming Hs/Vs geometry, locks after consecutive good
// frames and reconstructs screen coordinates from the sync stream.
module vga_sync_detector
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL     = VGA_H_TOTAL,
   parameter int V_TOTAL     = VGA_V_TOTAL,
   parameter int H_TOL       = VGA_H_TOL,
   parameter int H_ACT_OFS   = VGA_H_ACT_OFS,
   parameter int V_ACT_OFS   = VGA_V_ACT_OFS,
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
   input  logic        PIXEL_CLOCK,
   input  logic        RESET_N,
   input  logic        HS_IN,
   input  logic        VS_IN,
   output logic        LOCKED,
   output logic        ON_SCREEN,
   output logic [9:0]  SCREEN_X,
   output logic [9:0]  SCREEN_Y,
   output logic        NEW_FRAME,
   output logic [10:0] LINE_LEN,
   output logic [9:0]  FRAME_LINES
);

   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam logic [10:0] HCNT_MAX = '1;
   localparam logic [9:0]  VCNT_MAX = '1;
   localparam logic [10:0] TIMEOUT  = 11'(2 * H_TOTAL);

   logic hfall;
   logic vfall;

   sync_edge_detect u_hs (
      .clk     (PIXEL_CLOCK),
      .rst_n   (RESET_N),
      .sync_in (HS_IN),
      .fall    (hfall)
   );

   sync_edge_detect u_vs (
      .clk     (PIXEL_CLOCK),
      .rst_n   (RESET_N),
      .sync_in (VS_IN),
      .fall    (vfall)
   );

   sync_state_e state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [10:0]   hcnt_q, hcnt_d, len_d;
   logic [9:0]    vcnt_q, vcnt_d;
   logic          vpend_q, vpend_d;
   logic          frame_ref;
   logic          line_good;
   logic          frame_good;
   logic          timeout;
   logic          h_vis, v_vis;

   always_comb begin
      // Same-cycle hfall+vfall makes that hfall the reference
      frame_ref  = hfall & (vpend_q | vfall);
      len_d      = hcnt_q + 11'd1;
      line_good  = (len_d >= 11'(H_TOTAL - H_TOL))
                && (len_d <= 11'(H_TOTAL + H_TOL));
      frame_good = line_good
                && ((vcnt_q + 10'd1) == 10'(V_TOTAL));
      timeout    = (hcnt_q == TIMEOUT);

      hcnt_d = hcnt_q;
      if (hfall)
         hcnt_d = '0;
      else if (hcnt_q != HCNT_MAX)
         hcnt_d = hcnt_q + 11'd1;

      vcnt_d = vcnt_q;
      if (frame_ref)
         vcnt_d = '0;
      else if (hfall && (vcnt_q != VCNT_MAX))
         vcnt_d = vcnt_q + 10'd1;

      vpend_d = vpend_q;
      if (frame_ref)
         vpend_d = 1'b0;
      else if (vfall)
         vpend_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      unique case (state_q)
         S_SEARCH: begin
            if (frame_ref) begin
               state_d = S_VERIFY;
               good_d  = '0;
            end
         end
         S_VERIFY: begin
            if (timeout || (hfall && !line_good)) begin
               state_d = S_SEARCH;
            end else if (frame_ref) begin
               if (!frame_good) begin
                  state_d = S_SEARCH;
               end else begin
                  good_d = good_q + 1'b1;
                  if (good_d == GW'(LOCK_FRAMES))
                     state_d = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (timeout || (hfall && !line_good)
                || (frame_ref && !frame_good))
               state_d = S_SEARCH;
         end
         default: begin
            state_d = S_SEARCH;
         end
      endcase
   end

   always_comb begin
      h_vis = (hcnt_d >= 11'(H_ACT_OFS))
           && (hcnt_d < 11'(H_ACT_OFS + H_ACTIVE));
      v_vis = (vcnt_d >= 10'(V_ACT_OFS))
           && (vcnt_d < 10'(V_ACT_OFS + V_ACTIVE));
   end

   always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_SEARCH;
         good_q      <= '0;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         vpend_q     <= 1'b0;
         LOCKED      <= 1'b0;
         ON_SCREEN   <= 1'b0;
         SCREEN_X    <= '0;
         SCREEN_Y    <= '0;
         NEW_FRAME   <= 1'b0;
         LINE_LEN    <= '0;
         FRAME_LINES <= '0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         vpend_q   <= vpend_d;
         LOCKED    <= (state_d == S_LOCKED);
         NEW_FRAME <= frame_ref;
         if (hfall)
            LINE_LEN <= len_d;
         if (frame_ref)
            FRAME_LINES <= vcnt_q + 10'd1;
         // Coordinates come from next-state counters so they align with hcnt/vcnt
         SCREEN_X  <= hcnt_d[9:0] - 10'(H_ACT_OFS);
         SCREEN_Y  <= vcnt_d - 10'(V_ACT_OFS);
         ON_SCREEN <= (state_d == S_LOCKED) && h_vis && v_vis;
      end
   end

endmodule

// File: tb/tb_vga_sync_detector.sv
// Scoreboard bench for vga_sync_detector on a scaled-down raster
// (40x20 total, 24x12 visible) so several frames fit a short run.
`timescale 1ns/1ps
module tb_vga_sync_detector;

   localparam int HT = 40;
   localparam int VT = 20;
   localparam int HW = 6;
   localparam int HO = 8;
   localparam int VO = 4;
   localparam int HA = 24;
   localparam int VA = 12;
   localparam int NEVER = 1000000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hs = 1'b1;
   logic vs = 1'b1;
   logic locked, on_screen, new_frame;
   logic [9:0] sx, sy, fl;
   logic [10:0] ll;

   typedef struct {
      int fl;
      int len;
      int lk;
      int on;
   } exp_t;

   exp_t sb[$];
   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vga_sync_detector #(
      .H_TOTAL     (HT),
      .V_TOTAL     (VT),
      .H_TOL       (2),
      .H_ACT_OFS   (HO),
      .V_ACT_OFS   (VO),
      .H_ACTIVE    (HA),
      .V_ACTIVE    (VA),
      .LOCK_FRAMES (2)
   ) dut (
      .PIXEL_CLOCK (clk),
      .RESET_N     (rst_n),
      .HS_IN       (hs),
      .VS_IN       (vs),
      .LOCKED      (locked),
      .ON_SCREEN   (on_screen),
      .SCREEN_X    (sx),
      .SCREEN_Y    (sy),
      .NEW_FRAME   (new_frame),
      .LINE_LEN    (ll),
      .FRAME_LINES (fl)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_on_screen"}, int'(on_screen), 0);
      check({tag, "_new_frame"}, int'(new_frame), 0);
      check({tag, "_line_len"}, int'(ll), 0);
      check({tag, "_frame_lines"}, int'(fl), 0);
      check({tag, "_screen_x"}, int'(sx), 0);
      check({tag, "_screen_y"}, int'(sy), 0);
   endtask

   // One line: Hs low for HW clocks; Vs low from column vs_from on.
   // With watch_len set, expect LOCKED to fall as LINE_LEN shows it.
   task automatic send_line(input int len, input int vs_from,
                            input int watch_len);
      bit found;
      bit prev_lk;
      found = 1'b0;
      prev_lk = locked;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         if (watch_len > 0 && !found && int'(ll) == watch_len) begin
            found = 1'b1;
            check("locked_after_bad_hfall", int'(locked), 0);
            check("locked_before_bad_hfall", int'(prev_lk), 1);
         end
         prev_lk = locked;
         hs = (c < HW) ? 1'b0 : 1'b1;
         vs = (c >= vs_from) ? 1'b0 : 1'b1;
      end
      if (watch_len > 0)
         check("bad_line_seen", int'(found), 1);
   endtask

   // Pushes the expectation for the reference at this frame's start,
   // which reports on the previous frame.
   task automatic send_frame(input int nl,
                             input int la, input int lena,
                             input int lb, input int lenb,
                             input int wl,
                             input int efl, input int elk, input int eon);
      exp_t e;
      e.fl = efl;
      e.len = HT;
      e.lk = elk;
      e.on = eon;
      sb.push_back(e);
      for (int l = 0; l < nl; l++) begin
         int len;
         len = (l == la) ? lena : (l == lb) ? lenb : HT;
         send_line(len, (l < 2) ? 0 : NEVER,
                   (wl > 0 && l == la + 1) ? wl : 0);
      end
   endtask

   task automatic good_frame(input int efl, input int elk, input int eon);
      send_frame(VT, -1, 0, -1, 0, 0, efl, elk, eon);
   endtask

   initial begin : monitor
      int on_cnt;
      bit first;
      exp_t e;
      on_cnt = 0;
      first = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            on_cnt = 0;
            first = 1'b0;
         end else begin
            if (new_frame) begin
               if (sb.size() == 0) begin
                  check("unexpected_new_frame", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("frame_lines", int'(fl), e.fl);
                  check("line_len", int'(ll), e.len);
                  check("locked_at_ref", int'(locked), e.lk);
                  check("on_screen_cycles", on_cnt, e.on);
               end
               on_cnt = 0;
               first = 1'b0;
            end
            if (on_screen) begin
               if (!first) begin
                  check("first_visible_x", int'(sx), 0);
                  check("first_visible_y", int'(sy), 0);
                  first = 1'b1;
               end
               on_cnt++;
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit found;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      send_line(HT, NEVER, 0);
      send_line(HT, NEVER, 0);
      good_frame(3, 0, 0);
      good_frame(VT, 0, 0);
      good_frame(VT, 1, 0);
      good_frame(VT, 1, HA * VA);
      send_frame(VT, 3, HT + 2, 7, HT - 2, 0, VT, 1, HA * VA);
      send_frame(VT, 5, HT + 3, -1, 0, HT + 3, VT, 1, HA * VA);
      good_frame(VT, 0, 2 * HA);
      good_frame(VT, 0, 0);
      good_frame(VT, 1, 0);
      send_frame(VT - 1, -1, 0, -1, 0, 0, VT, 1, HA * VA);
      good_frame(VT - 1, 0, HA * VA);
      good_frame(VT, 0, 0);
      good_frame(VT, 0, 0);
      send_frame(6, -1, 0, -1, 0, 0, VT, 1, 0);

      check("locked_before_reset", int'(locked), 1);
      #2;
      rst_n = 1'b0;
      hs = 1'b1;
      vs = 1'b1;
      #1;
      check_zero("async_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      send_line(HT, NEVER, 0);
      send_line(HT, NEVER, 0);
      send_line(HT, 20, 0);
      good_frame(4, 0, 0);
      good_frame(VT, 0, 0);
      send_frame(2, -1, 0, -1, 0, 0, VT, 1, 0);

      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!found && !locked) begin
            found = 1'b1;
            check("timeout_before_hfall_len", int'(ll), HT);
         end
         hs = (c < HW) ? 1'b0 : 1'b1;
         vs = 1'b1;
      end
      check("timeout_drops_lock", int'(found), 1);

      for (int c = 0; c < 2100; c++) begin
         @(negedge clk);
         hs = (c < HW) ? 1'b0 : 1'b1;
      end
      check("hcnt_saturated_x", int'(sx), 1015);
      check("locked_after_timeout", int'(locked), 0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
